// File: rtl/wb_uart_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the buffered UART.
// Grants lock for the whole CYC; a watchdog returns ERR and aborts a silent slave.
module wb_uart_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [1:0]  i_m_cyc,
  input  logic [1:0]  i_m_stb,
  input  logic [1:0]  i_m_we,
  input  logic [7:0]  i_m_sel,
  input  logic [59:0] i_m_addr,
  input  logic [63:0] i_m_data,
  output logic [1:0]  o_m_stall,
  output logic [1:0]  o_m_ack,
  output logic [1:0]  o_m_err,
  output logic [31:0] o_m_data,
  output logic        o_s_cyc,
  output logic        o_s_stb,
  output logic        o_s_we,
  output logic [3:0]  o_s_sel,
  output logic [29:0] o_s_addr,
  output logic [31:0] o_s_data,
  input  logic        i_s_stall,
  input  logic        i_s_ack,
  input  logic        i_s_err,
  input  logic [31:0] i_s_data,
  output logic        o_owner,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, OWN, ABORT} state_t;

  state_t        state, state_nx;
  logic          owner, owner_nx;
  logic          last, last_nx;
  logic [3:0]    outst, outst_nx;
  logic [TW-1:0] timer, timer_nx;

  logic own_cyc, own_stb, other, full, live, resp, timeout, accept;

  assign own_cyc = i_m_cyc[owner];
  assign own_stb = i_m_stb[owner];
  assign other   = ~owner;
  assign full    = (outst == 4'd15);
  assign live    = (outst != 4'd0);
  assign resp    = i_s_ack | i_s_err;
  // A slave response on the expiry cycle wins over the watchdog.
  assign timeout = (state == OWN) && own_cyc && (timer == TW'(TIMEOUT)) && !resp;
  assign accept  = (state == OWN) && own_cyc && own_stb && !full && !i_s_stall && !timeout;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      outst <= 4'd0;
      timer <= '0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      last  <= last_nx;
      outst <= outst_nx;
      timer <= timer_nx;
    end
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last;
    outst_nx = outst;
    timer_nx = timer;
    case (state)
      IDLE: begin
        outst_nx = 4'd0;
        timer_nx = '0;
        if (|i_m_cyc) begin
          state_nx = OWN;
          owner_nx = (&i_m_cyc) ? ~last : i_m_cyc[1];
          last_nx  = owner_nx;
        end
      end
      OWN, ABORT: begin
        if (!own_cyc) begin
          outst_nx = 4'd0;
          timer_nx = '0;
          if (i_m_cyc[other]) begin
            state_nx = OWN;
            owner_nx = other;
            last_nx  = other;
          end else begin
            state_nx = IDLE;
          end
        end else if (state == OWN) begin
          if (timeout) begin
            state_nx = ABORT;
            outst_nx = 4'd0;
            timer_nx = '0;
          end else begin
            outst_nx = outst + {3'b000, accept} - {3'b000, resp & live};
            timer_nx = (resp || !live) ? '0 : timer + TW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_s_cyc   = 1'b0;
    o_s_stb   = 1'b0;
    o_s_we    = 1'b0;
    o_s_sel   = 4'h0;
    o_s_addr  = 30'h0;
    o_s_data  = 32'h0;
    o_m_stall = 2'b11;
    o_m_ack   = 2'b00;
    o_m_err   = 2'b00;
    if (state == OWN) begin
      o_s_we   = owner ? i_m_we[1]        : i_m_we[0];
      o_s_sel  = owner ? i_m_sel[7:4]     : i_m_sel[3:0];
      o_s_addr = owner ? i_m_addr[59:30]  : i_m_addr[29:0];
      o_s_data = owner ? i_m_data[63:32]  : i_m_data[31:0];
      if (timeout) begin
        o_m_err[owner] = 1'b1;
      end else begin
        o_s_cyc          = own_cyc;
        o_s_stb          = own_stb & ~full;
        o_m_stall[owner] = i_s_stall | full;
        // Responses with nothing outstanding belong to an aborted cycle.
        o_m_ack[owner]   = i_s_ack & live;
        o_m_err[owner]   = i_s_err & live;
      end
    end
  end

  assign o_m_data = i_s_data;
  assign o_owner  = owner;
  assign o_busy   = (state != IDLE);

endmodule
